// File: rtl/sm_qam_mapper.sv
// Serial-bit to BPSK/QPSK/16-QAM Gray mapper with a registered output FIFO.
// Optional status counters (sym_cnt, ovf) are built when SM_STATUS_EN is defined.
module sm_qam_mapper #(
  parameter int unsigned OUT_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             flush,
  input  logic             din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] I_out,
  output logic [OUT_W-1:0] Q_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SM_STATUS_EN
  ,
  output logic [15:0]      sym_cnt,
  output logic             ovf
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ModeBpsk  = 2'd0,
    ModeQpsk  = 2'd1,
    ModeQam16 = 2'd2,
    ModeRsvd  = 2'd3
  } mode_e;

  // Binary-antipodal level: 0 -> -1, 1 -> +1.
  function automatic logic [OUT_W-1:0] lvl2(input logic b);
    return b ? OUT_W'(1) : OUT_W'(-1);
  endfunction

  // Gray-coded 4-PAM level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
  function automatic logic [OUT_W-1:0] lvl4(input logic [1:0] b);
    logic [OUT_W-1:0] l;
    case (b)
      2'b00:   l = OUT_W'(-3);
      2'b01:   l = OUT_W'(-1);
      2'b11:   l = OUT_W'(1);
      default: l = OUT_W'(3);
    endcase
    return l;
  endfunction

  logic [2:0]       acc_q;
  logic [2:0]       cnt_q, cnt_d;
  mode_e            smode_q, smode_d, smode_cur;
  logic [3:0]       word;
  logic [2:0]       sym_len;
  logic             accept, push, pop;
  logic [OUT_W-1:0] map_i, map_q;

  logic [OUT_W-1:0] mem_i [DEPTH];
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      occ_q, occ_d;

  assign in_ready  = (occ_q != (AW+1)'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign I_out     = out_valid ? mem_i[rd_q] : '0;
  assign Q_out     = out_valid ? mem_q[rd_q] : '0;

  assign accept = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready;
  // Full 4-bit word including the bit arriving this cycle, MSB first.
  assign word   = {acc_q, din};

  always_comb begin
    // The mode input only matters on the first bit of a symbol.
    smode_cur = (cnt_q == 3'd0) ? mode_e'(mode) : smode_q;
    case (smode_cur)
      ModeBpsk:  sym_len = 3'd1;
      ModeQam16: sym_len = 3'd4;
      default:   sym_len = 3'd2;
    endcase
  end

  always_comb begin
    case (smode_cur)
      ModeBpsk: begin
        map_i = lvl2(word[0]);
        map_q = '0;
      end
      ModeQam16: begin
        map_i = lvl4(word[3:2]);
        map_q = lvl4(word[1:0]);
      end
      default: begin
        map_i = lvl2(word[1]);
        map_q = lvl2(word[0]);
      end
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    smode_d = smode_q;
    push    = 1'b0;
    if (flush) begin
      cnt_d = 3'd0;
    end else if (accept) begin
      if (cnt_q == 3'd0) begin
        smode_d = smode_cur;
      end
      if (cnt_q + 3'd1 == sym_len) begin
        push  = 1'b1;
        cnt_d = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      smode_q <= ModeQpsk;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      if (accept) begin
        acc_q <= word[2:0];
      end
      cnt_q   <= cnt_d;
      smode_q <= smode_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
    end
  end

  // Storage needs no reset: out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_q] <= map_i;
      mem_q[wr_q] <= map_q;
    end
  end

`ifdef SM_STATUS_EN
  logic [15:0] sym_cnt_q;
  logic        ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) begin
        sym_cnt_q <= sym_cnt_q + 16'd1;
      end
      if (in_valid && !in_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign sym_cnt = sym_cnt_q;
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_sm_qam_mapper.sv
// Randomised and directed bench for sm_qam_mapper against a queue-based symbol model.
// Status ports are exercised when SM_STATUS_EN is defined.
module tb_sm_qam_mapper;
  localparam int OUT_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd1;
  logic             flush = 1'b0;
  logic             din = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] I_out, Q_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef SM_STATUS_EN
  logic [15:0]      sym_cnt;
  logic             ovf;
`endif

  sm_qam_mapper #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .flush     (flush),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I_out     (I_out),
    .Q_out     (Q_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SM_STATUS_EN
    ,
    .sym_cnt   (sym_cnt),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a queue of (I, Q) integers and the bits of the symbol being built.
  int   eq_i[$];
  int   eq_q[$];
  int   m_cnt = 0;
  int   m_len = 2;
  int   m_bits[$];
  int   m_pushed = 0;
  bit   m_ovf = 0;

  function automatic int sym_len(input logic [1:0] md);
    if (md == 2'd0) return 1;
    if (md == 2'd2) return 4;
    return 2;
  endfunction

  function automatic int pam4(input int hi, input int lo);
    int tbl[4];
    tbl = '{-3, -1, 3, 1};
    return tbl[hi * 2 + lo];
  endfunction

  task automatic model_reset();
    eq_i.delete();
    eq_q.delete();
    m_bits.delete();
    m_cnt = 0;
    m_len = 2;
    m_pushed = 0;
    m_ovf = 0;
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic tick(input logic v, input logic d, input logic f, input logic [1:0] md,
                      input logic ordy);
    bit acc, pp;
    in_valid  = v;
    din       = d;
    flush     = f;
    mode      = md;
    out_ready = ordy;
    acc = v && (eq_i.size() < DEPTH) && !f;
    pp  = (eq_i.size() > 0) && ordy;
    if (v && eq_i.size() >= DEPTH) m_ovf = 1;
    @(posedge clk);
    if (pp) begin
      void'(eq_i.pop_front());
      void'(eq_q.pop_front());
    end
    if (f) begin
      m_cnt = 0;
      m_bits.delete();
    end else if (acc) begin
      if (m_cnt == 0) m_len = sym_len(md);
      m_bits.push_back(int'(d));
      m_cnt++;
      if (m_cnt == m_len) begin
        if (m_len == 1) begin
          eq_i.push_back(m_bits[0] ? 1 : -1);
          eq_q.push_back(0);
        end else if (m_len == 2) begin
          eq_i.push_back(m_bits[0] ? 1 : -1);
          eq_q.push_back(m_bits[1] ? 1 : -1);
        end else begin
          eq_i.push_back(pam4(m_bits[0], m_bits[1]));
          eq_q.push_back(pam4(m_bits[2], m_bits[3]));
        end
        m_pushed++;
        m_cnt = 0;
        m_bits.delete();
      end
    end
    #1;
  endtask

  // Flush any partial symbol and drain the FIFO.
  task automatic settle();
    for (int k = 0; k < DEPTH + 1; k++) tick(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nvec += 4;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (I_out !== '0) begin nerr++; $display("FAIL reset_I got %0d want 0", $signed(I_out)); end
    if (Q_out !== '0) begin nerr++; $display("FAIL reset_Q got %0d want 0", $signed(Q_out)); end
`ifdef SM_STATUS_EN
    nvec += 2;
    if (sym_cnt !== 16'd0) begin nerr++; $display("FAIL reset_sym_cnt got %0d want 0", sym_cnt); end
    if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_qpsk();
    int want_i[2];
    int want_q[2];
    logic b[4];
    want_i = '{1, -1};
    want_q = '{-1, 1};
    b = '{1'b1, 1'b0, 1'b0, 1'b1};
    settle();
    for (int s = 0; s < 2; s++) begin
      tick(1'b1, b[2*s], 1'b0, 2'd1, 1'b1);
      nvec++;
      if (out_valid !== 1'b0) begin nerr++; $display("FAIL qpsk_mid_valid%0d got %b want 0", s, out_valid); end
      tick(1'b1, b[2*s+1], 1'b0, 2'd1, 1'b1);
      nvec += 3;
      if (out_valid !== 1'b1) begin nerr++; $display("FAIL qpsk_valid%0d got %b want 1", s, out_valid); end
      if ($signed(I_out) !== want_i[s]) begin nerr++; $display("FAIL qpsk_I%0d got %0d want %0d", s, $signed(I_out), want_i[s]); end
      if ($signed(Q_out) !== want_q[s]) begin nerr++; $display("FAIL qpsk_Q%0d got %0d want %0d", s, $signed(Q_out), want_q[s]); end
    end
  endtask

  task automatic test_qam16();
    int want_i[2];
    int want_q[2];
    logic b[8];
    want_i = '{3, -3};
    want_q = '{-1, 1};
    b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    settle();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) tick(1'b1, b[4*s+k], 1'b0, 2'd2, 1'b1);
      nvec += 3;
      if (out_valid !== 1'b1) begin nerr++; $display("FAIL qam_valid%0d got %b want 1", s, out_valid); end
      if ($signed(I_out) !== want_i[s]) begin nerr++; $display("FAIL qam_I%0d got %0d want %0d", s, $signed(I_out), want_i[s]); end
      if ($signed(Q_out) !== want_q[s]) begin nerr++; $display("FAIL qam_Q%0d got %0d want %0d", s, $signed(Q_out), want_q[s]); end
    end
  endtask

  task automatic test_bpsk();
    logic b[3];
    b = '{1'b1, 1'b0, 1'b1};
    settle();
    for (int s = 0; s < 3; s++) begin
      tick(1'b1, b[s], 1'b0, 2'd0, 1'b1);
      nvec += 3;
      if (out_valid !== 1'b1) begin nerr++; $display("FAIL bpsk_valid%0d got %b want 1", s, out_valid); end
      if ($signed(I_out) !== (b[s] ? 1 : -1)) begin nerr++; $display("FAIL bpsk_I%0d got %0d want %0d", s, $signed(I_out), b[s] ? 1 : -1); end
      if ($signed(Q_out) !== 0) begin nerr++; $display("FAIL bpsk_Q%0d got %0d want 0", s, $signed(Q_out)); end
    end
  endtask

  task automatic test_full();
    int xi[$];
    int xq[$];
    settle();
    for (int k = 0; k < 2 * DEPTH + 2; k++) begin
      tick(1'b1, 1'($urandom_range(1)), 1'b0, 2'd1, 1'b0);
      nvec++;
      if (in_ready !== (eq_i.size() < DEPTH)) begin
        nerr++; $display("FAIL full_in_ready%0d got %b want %b", k, in_ready, eq_i.size() < DEPTH);
      end
    end
    nvec += 2;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL full_final_ready got %b want 0", in_ready); end
    if (eq_i.size() != DEPTH) begin nerr++; $display("FAIL full_model_depth got %0d want %0d", eq_i.size(), DEPTH); end
`ifdef SM_STATUS_EN
    nvec++;
    if (ovf !== 1'b1) begin nerr++; $display("FAIL full_ovf got %b want 1", ovf); end
`endif
    xi = eq_i;
    xq = eq_q;
    for (int k = 0; k < DEPTH; k++) begin
      nvec += 3;
      if (out_valid !== 1'b1) begin nerr++; $display("FAIL full_drain_valid%0d got %b want 1", k, out_valid); end
      if ($signed(I_out) !== xi[k]) begin nerr++; $display("FAIL full_drain_I%0d got %0d want %0d", k, $signed(I_out), xi[k]); end
      if ($signed(Q_out) !== xq[k]) begin nerr++; $display("FAIL full_drain_Q%0d got %0d want %0d", k, $signed(Q_out), xq[k]); end
      tick(1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
      if (k == 0) begin
        nvec++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
      end
    end
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL full_empty_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    settle();
    tick(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 2'd2, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_early_valid got %b want 0", out_valid); end
    tick(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    nvec += 3;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL flush_valid got %b want 1", out_valid); end
    if ($signed(I_out) !== 1) begin nerr++; $display("FAIL flush_I got %0d want 1", $signed(I_out)); end
    if ($signed(Q_out) !== 1) begin nerr++; $display("FAIL flush_Q got %0d want 1", $signed(Q_out)); end
    tick(1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_single_symbol got %b want 0", out_valid); end
  endtask

  task automatic test_mode_reset();
    settle();
    tick(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    nvec += 3;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL modesw_valid got %b want 1", out_valid); end
    if ($signed(I_out) !== 1) begin nerr++; $display("FAIL modesw_I got %0d want 1", $signed(I_out)); end
    if ($signed(Q_out) !== -1) begin nerr++; $display("FAIL modesw_Q got %0d want -1", $signed(Q_out)); end
    for (int k = 0; k < 4; k++) tick(1'b1, 1'(k), 1'b0, 2'd1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL modesw_ready3 got %b want 1", in_ready); end
    rst_n = 1'b0;
    #1;
    nvec += 4;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    if (I_out !== '0) begin nerr++; $display("FAIL rst_mid_I got %0d want 0", $signed(I_out)); end
    if (Q_out !== '0) begin nerr++; $display("FAIL rst_mid_Q got %0d want 0", $signed(Q_out)); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
    nvec += 3;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
    if ($signed(I_out) !== -1) begin nerr++; $display("FAIL post_rst_I got %0d want -1", $signed(I_out)); end
    if ($signed(Q_out) !== 1) begin nerr++; $display("FAIL post_rst_Q got %0d want 1", $signed(Q_out)); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(15) == 0),
           2'($urandom_range(3)), ($urandom_range(3) != 0));
      nvec += 2;
      if (in_ready !== (eq_i.size() < DEPTH)) begin
        nerr++; $display("FAIL rand_ready%0d got %b want %b", k, in_ready, eq_i.size() < DEPTH);
      end
      if (out_valid !== (eq_i.size() > 0)) begin
        nerr++; $display("FAIL rand_valid%0d got %b want %b", k, out_valid, eq_i.size() > 0);
      end
      if (eq_i.size() > 0) begin
        nvec += 2;
        if ($signed(I_out) !== eq_i[0]) begin nerr++; $display("FAIL rand_I%0d got %0d want %0d", k, $signed(I_out), eq_i[0]); end
        if ($signed(Q_out) !== eq_q[0]) begin nerr++; $display("FAIL rand_Q%0d got %0d want %0d", k, $signed(Q_out), eq_q[0]); end
      end
    end
`ifdef SM_STATUS_EN
    nvec += 2;
    if (sym_cnt !== 16'(m_pushed)) begin nerr++; $display("FAIL rand_sym_cnt got %0d want %0d", sym_cnt, m_pushed); end
    if (ovf !== m_ovf) begin nerr++; $display("FAIL rand_ovf got %b want %b", ovf, m_ovf); end
`endif
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_qam16();
    test_bpsk();
    test_full();
    test_flush();
    test_mode_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sm_qam_mapper.md
# sm_qam_mapper

Parametrised, registered signal mapper for the baseband transmit chain: accepts the serial bit stream from the serial-to-parallel stage one bit per handshake and groups bits into symbols of 1, 2 or 4 bits (BPSK/QPSK/16-QAM, selected at run time). Each complete symbol is Gray-mapped to signed I/Q levels and queued in an output FIFO with a valid/ready handshake toward the pulse-shaping stage. It is the next-generation replacement for the fixed combinational 2-bit QPSK mapper.

## Interface
- OUT_W, 4: signed I/Q output width, two's complement; minimum 3.
- DEPTH, 4: output FIFO depth in symbols; power of two, minimum 2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  0 = BPSK, 1 = QPSK, 2 = 16-QAM, 3 = reserved (treated as QPSK).
- flush  in  1  discard the partially accumulated symbol.
- din  in  1  serial data bit, first bit = symbol MSB.
- in_valid  in  1  din valid.
- in_ready  out  1  mapper can accept a bit.
- I_out  out  OUT_W  in-phase level of head-of-FIFO symbol.
- Q_out  out  OUT_W  quadrature level of head-of-FIFO symbol.
- out_valid  out  1  I_out/Q_out hold a valid symbol.
- out_ready  in  1  downstream accepts the symbol.

## Operation
- Bit accepted on a rising edge with in_valid && in_ready; shifted into a 4-bit accumulator MSB-first; bit counter increments.
- mode latched into an internal symbol-mode register when the first bit of a symbol is accepted (bit counter = 0); mode changes mid-symbol have no effect until the next symbol.
- Symbol complete when bit counter reaches N = 1/2/4 (BPSK/QPSK/16-QAM); on that edge the mapped symbol is written into the FIFO and the counter returns to 0.
- Gray mapping, levels sign-extended to OUT_W:
  - BPSK b0: 0 -> I = -1, 1 -> I = +1; Q = 0.
  - QPSK b1 b0: I from b1, Q from b0; 0 -> -1, 1 -> +1.
  - 16-QAM b3 b2 -> I, b1 b0 -> Q: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
- in_ready = FIFO not full; deasserts regardless of accumulator position.
- Output pop on rising edge with out_valid && out_ready; out_valid = FIFO not empty; I_out/Q_out driven from FIFO head (no bubble).
- flush: on the edge it is high, bit counter cleared and any bit presented that cycle is dropped (flush has priority); FIFO contents untouched.
- Push and pop on the same edge: occupancy unchanged, both take effect.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release): in_ready = 1, out_valid = 0, I_out = 0, Q_out = 0, accumulator, bit counter, FIFO pointers/occupancy = 0, symbol-mode = QPSK.
- Latency: symbol visible on I_out/Q_out with out_valid = 1 immediately after the edge that accepts its last bit, if FIFO was empty (1 cycle).
- Throughput: 1 bit/cycle in; up to 1 symbol/cycle out.
- Full: in_ready = 0 in the cycle after the DEPTH-th write with no pop; returns to 1 the cycle after a pop.
- Reset mid-symbol or with FIFO occupied: all state discarded, no symbol emitted.

## Configuration
- SM_STATUS_EN defined: adds ports sym_cnt (out, 16) counting symbols pushed into the FIFO (wraps at 65535 -> 0) and ovf (out, 1), sticky, set when in_valid is high while in_ready is low; both cleared only by rst_n.
- Undefined: ports and logic absent; mapping and handshake behaviour identical.

## Test plan
- QPSK, bits 1,0 then 0,1, out_ready = 1 -> symbols (I,Q) = (+1,-1) then (-1,+1), each valid one cycle after its 2nd bit.
- 16-QAM, bits 1,0,0,1 -> (I,Q) = (+3,-1); bits 0,0,1,1 -> (-3,+1).
- BPSK, bits 1,0,1 -> I = +1,-1,+1, Q = 0, one symbol per cycle.
- out_ready = 0, QPSK, 2*DEPTH+2 bits offered -> in_ready drops after DEPTH symbols stored; release out_ready -> DEPTH symbols in order, no loss; with SM_STATUS_EN ovf = 1.
- 16-QAM, 2 bits then flush with in_valid = 1, then 1,1,1,1 -> single symbol (+1,+1), flushed bits absent.
- Mode switched QPSK -> 16-QAM after 1st bit of a symbol; rst_n pulsed with FIFO holding 3 symbols -> current symbol completes as QPSK; after reset out_valid = 0, in_ready = 1, outputs 0.
